// File: rtl/step_pkg.sv
// Shared types and constants for the step_controller arbiter.
package step_pkg;

   // Default operand/result width of the shared step_controller.
   localparam int DATA_W_DEF = 8;

   // Arbiter sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

   // Stage encodings of the existing step_controller pipeline.
   localparam logic [1:0] SC_ADD     = 2'd0;
   localparam logic [1:0] SC_MUL     = 2'd1;
   localparam logic [1:0] SC_SPECIAL = 2'd2;
   localparam logic [1:0] SC_END     = 2'd3;

   // Width of a requester index; at least one bit.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/step_arbiter_if.sv
// Requester-side bus: level requests with operands, one-hot response strobe.
interface step_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8
) ();
   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]       rsp_data;
   logic                    rsp_err;

   // Requester side drives requests and consumes responses.
   modport master (output req, output req_data,
                   input rsp_valid, input rsp_data, input rsp_err);

   // Arbiter side consumes requests and drives responses.
   modport slave  (input req, input req_data,
                   output rsp_valid, output rsp_data, output rsp_err);
endinterface

// File: rtl/step_arbiter_rr_pick.sv
// Round-robin picker: rotate so the port after the last winner sits at bit 0,
// take the lowest set bit, then rotate the offset back to a port index.
module rr_pick
   import step_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = id_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  last_id,
   output logic [ID_W-1:0]  gnt_id,
   output logic             any
);
   logic [ID_W-1:0]  start;
   logic [N_REQ-1:0] rot;
   logic [ID_W-1:0]  off;

   // Search begins one past the previous winner, wrapping at N_REQ.
   assign start = (last_id == ID_W'(N_REQ - 1)) ? '0 : last_id + 1'b1;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
         assign rot[gi] = req[ID_W'((int'(start) + gi) % N_REQ)];
      end
   endgenerate

   // Priority encode: the lowest rotated bit is the nearest port after last_id.
   always_comb begin
      off = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot[k]) off = ID_W'(k);
      end
   end

   assign gnt_id = ID_W'((int'(start) + int'(off)) % N_REQ);
   assign any    = |req;

endmodule

// File: rtl/step_arbiter.sv
// Round-robin sequencer sharing one step_controller between N_REQ requesters:
// grant, single-cycle start, wait for done or watchdog, then respond to the
// granted port only.
module step_arbiter
   import step_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   step_arbiter_if.slave     bus,
   output logic              sc_start,
   output logic [DATA_W-1:0] sc_data_in,
   input  logic [DATA_W-1:0] sc_data_out,
   input  logic              sc_done,
   output logic              busy,
   output logic              err_sticky
);
   localparam int ID_W    = id_width(N_REQ);
   localparam int TIMER_W = $clog2(TIMEOUT);

   arb_state_t         state_q;
   logic [ID_W-1:0]    gnt_q;
   logic [ID_W-1:0]    last_id_q;
   logic [DATA_W-1:0]  op_q;
   logic [TIMER_W-1:0] timer_q;
   logic               sc_start_q;
   logic [N_REQ-1:0]   rsp_valid_q;
   logic [DATA_W-1:0]  rsp_data_q;
   logic               rsp_err_q;
   logic               err_sticky_q;

   logic [ID_W-1:0]    pick_gnt;
   logic               pick_any;
   logic [DATA_W-1:0]  op_d;

   rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
      .req     (bus.req),
      .last_id (last_id_q),
      .gnt_id  (pick_gnt),
      .any     (pick_any)
   );

   // Operand of the port that would be granted this cycle.
   assign op_d = bus.req_data[int'(pick_gnt)*DATA_W +: DATA_W];

   // Sequencer FSM; every output is a register so nothing glitches downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         gnt_q        <= '0;
         last_id_q    <= ID_W'(N_REQ - 1);
         op_q         <= '0;
         timer_q      <= '0;
         sc_start_q   <= 1'b0;
         rsp_valid_q  <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
         err_sticky_q <= 1'b0;
      end else begin
         sc_start_q  <= 1'b0;
         rsp_valid_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (pick_any) begin
                  // Operand is captured only here; later req_data changes are ignored.
                  gnt_q      <= pick_gnt;
                  op_q       <= op_d;
                  sc_start_q <= 1'b1;
                  state_q    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               timer_q <= '0;
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               timer_q <= timer_q + 1'b1;
               // Done takes precedence over a coincident watchdog expiry.
               if (sc_done) begin
                  rsp_data_q  <= sc_data_out;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= N_REQ'(1) << gnt_q;
                  state_q     <= ST_RESP;
               end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                  // step_controller cannot be aborted; err_sticky tells the system to reset it.
                  rsp_data_q   <= '0;
                  rsp_err_q    <= 1'b1;
                  err_sticky_q <= 1'b1;
                  rsp_valid_q  <= N_REQ'(1) << gnt_q;
                  state_q      <= ST_RESP;
               end
            end
            ST_RESP: begin
               last_id_q <= gnt_q;
               state_q   <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign sc_start      = sc_start_q;
   assign sc_data_in    = op_q;
   assign busy          = (state_q != ST_IDLE);
   assign err_sticky    = err_sticky_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_step_arbiter.sv
// Directed bench for step_arbiter; the step_controller is modelled inline by
// the stimulus thread, which drives sc_done/sc_data_out after a chosen delay.
module tb_step_arbiter;
   localparam int N_REQ   = 4;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic              sc_start;
   logic [DATA_W-1:0] sc_data_in;
   logic [DATA_W-1:0] sc_data_out;
   logic              sc_done;
   logic              busy;
   logic              err_sticky;

   int n_tests = 0;
   int n_fail  = 0;
   int n_start = 0;
   int n_rsp   = 0;

   step_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

   step_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .sc_start    (sc_start),
      .sc_data_in  (sc_data_in),
      .sc_data_out (sc_data_out),
      .sc_done     (sc_done),
      .busy        (busy),
      .err_sticky  (err_sticky)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled mid-cycle.
   always @(negedge clk) begin
      if (sc_start) n_start++;
      if (bus.rsp_valid != '0) n_rsp++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " busy"},       32'(busy), 32'd0);
      chk({tag, " sc_start"},   32'(sc_start), 32'd0);
      chk({tag, " sc_data_in"}, 32'(sc_data_in), 32'd0);
      chk({tag, " rsp_valid"},  32'(bus.rsp_valid), 32'd0);
      chk({tag, " rsp_data"},   32'(bus.rsp_data), 32'd0);
      chk({tag, " rsp_err"},    32'(bus.rsp_err), 32'd0);
      chk({tag, " err_sticky"}, 32'(err_sticky), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req = '0;
      sc_done = 1'b0;
      tick();
      tick();
      chk_reset_outputs("reset");
      rst = 1'b0;
   endtask

   // Called in an IDLE cycle with req already set. lat = WAIT cycle on which
   // sc_done is driven (0 = never, expect watchdog). Ends in the RESP cycle.
   task automatic serve(input int lat, input logic [7:0] res, input logic [3:0] exp_vld,
                        input logic [7:0] exp_op, input bit mid_change);
      int cyc;
      int starts0;
      int waits;
      cyc     = 1;
      starts0 = n_start;
      for (int i = 0; i < 4 && !sc_start; i++) begin
         tick();
         cyc++;
      end
      chk("issue sc_start", 32'(sc_start), 32'd1);
      chk("issue sc_data_in", 32'(sc_data_in), 32'(exp_op));
      chk("issue busy", 32'(busy), 32'd1);
      if (mid_change) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (exp_vld[i]) begin
               bus.req[i] = 1'b0;
               bus.req_data[i*DATA_W +: DATA_W] = 8'hEE;
            end
         end
      end
      waits = (lat == 0) ? TIMEOUT : lat;
      for (int k = 1; k <= waits; k++) begin
         tick();
         cyc++;
         if (k == lat) begin
            sc_done = 1'b1;
            sc_data_out = res;
         end
      end
      chk("wait sc_data_in hold", 32'(sc_data_in), 32'(exp_op));
      chk("wait sc_start low", 32'(sc_start), 32'd0);
      tick();
      cyc++;
      sc_done = 1'b0;
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_vld));
      chk("rsp_data", 32'(bus.rsp_data), (lat == 0) ? 32'd0 : 32'(res));
      chk("rsp_err", 32'(bus.rsp_err), (lat == 0) ? 32'd1 : 32'd0);
      chk("latency", 32'(cyc), 32'(3 + waits));
      chk("start count", 32'(n_start - starts0), 32'd1);
      $display("[TB] txn op=%02h vld=%04b data=%02h err=%0d cycles=%0d",
               exp_op, bus.rsp_valid, bus.rsp_data, bus.rsp_err, cyc);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rsp0;
      rst = 1'b1;
      sc_done = 1'b0;
      sc_data_out = '0;
      bus.req = '0;
      bus.req_data = '0;
      do_reset();

      // Single request from port 0, done on the 7th WAIT cycle.
      bus.req = 4'b0001;
      bus.req_data = 32'h0000_0012;
      serve(7, 8'h5A, 4'b0001, 8'h12, 1'b0);
      bus.req = '0;
      tick();
      chk("single busy after resp", 32'(busy), 32'd0);
      chk("single rsp_valid drop", 32'(bus.rsp_valid), 32'd0);

      // All four held: grants rotate 0,1,2,3,0.
      do_reset();
      bus.req = 4'b1111;
      bus.req_data = 32'h0403_0201;
      serve(2, 8'hA1, 4'b0001, 8'h01, 1'b0); tick();
      serve(3, 8'hB2, 4'b0010, 8'h02, 1'b0); tick();
      serve(1, 8'hC3, 4'b0100, 8'h03, 1'b0); tick();
      serve(4, 8'hD4, 4'b1000, 8'h04, 1'b0); tick();
      serve(2, 8'hA1, 4'b0001, 8'h01, 1'b0);
      bus.req = '0;
      tick();

      // Watchdog: port 3, done never arrives.
      bus.req = 4'b1000;
      bus.req_data = 32'h3300_0000;
      serve(0, 8'h00, 4'b1000, 8'h33, 1'b0);
      chk("timeout err_sticky", 32'(err_sticky), 32'd1);
      bus.req = '0;
      repeat (5) tick();
      chk("timeout err_sticky held", 32'(err_sticky), 32'd1);
      do_reset();

      // Done coincides with timer == TIMEOUT-1: done wins.
      bus.req = 4'b0010;
      bus.req_data = 32'h0000_4400;
      serve(TIMEOUT, 8'h99, 4'b0010, 8'h44, 1'b0);
      chk("coincide err_sticky", 32'(err_sticky), 32'd0);
      bus.req = '0;
      tick();

      // Stray done in IDLE is ignored.
      sc_done = 1'b1;
      sc_data_out = 8'hFF;
      tick();
      sc_done = 1'b0;
      chk("stray busy", 32'(busy), 32'd0);
      chk("stray sc_start", 32'(sc_start), 32'd0);
      chk("stray rsp_valid", 32'(bus.rsp_valid), 32'd0);
      tick();
      chk("stray busy later", 32'(busy), 32'd0);

      // Port 2 withdraws and changes its operand one cycle after grant.
      bus.req = 4'b0100;
      bus.req_data = 32'h005C_0000;
      serve(3, 8'h7E, 4'b0100, 8'h5C, 1'b1);
      bus.req = '0;
      tick();

      // Reset during WAIT: response lost, priority back to port 0.
      bus.req = 4'b0010;
      bus.req_data = 32'h0000_2100;
      tick();
      chk("rstwait issue", 32'(sc_start), 32'd1);
      repeat (3) tick();
      rsp0 = n_rsp;
      rst = 1'b1;
      bus.req = '0;
      tick();
      chk_reset_outputs("rst in wait");
      rst = 1'b0;
      repeat (12) tick();
      chk("rst in wait no rsp", 32'(n_rsp - rsp0), 32'd0);
      bus.req = 4'b1001;
      bus.req_data = 32'h0B00_000A;
      serve(2, 8'h5F, 4'b0001, 8'h0A, 1'b0);
      bus.req = '0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/step_arbiter.md
Name: step_arbiter

Overview:
Round-robin arbiter and sequencer that shares one step_controller pipeline (add -> mul -> special -> end) between N_REQ requesters. It accepts one 8-bit operand per request and issues a single-cycle start to the shared pipeline. It waits for done, or for a watchdog timeout, then returns the result to the granted requester only. It sits between the requester blocks and the step_controller instance, and owns that instance's start/data_in.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, operand/result width; must match step_controller
TIMEOUT, 64, max cycles in WAIT before abort (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req  in  N_REQ  level request per requester; held until its rsp_valid bit
req_data  in  N_REQ*DATA_W  operands, requester i at bits [i*DATA_W +: DATA_W]
sc_start  out  1  one-cycle start pulse to step_controller
sc_data_in  out  DATA_W  operand to step_controller
sc_data_out  in  DATA_W  step_controller result
sc_done  in  1  step_controller done pulse
rsp_valid  out  N_REQ  one-hot, one-cycle response strobe
rsp_data  out  DATA_W  result; valid when any rsp_valid bit is set
rsp_err  out  1  qualifies rsp_valid: 1 = timeout, rsp_data = 0
busy  out  1  high in every state except IDLE
err_sticky  out  1  set on any timeout, cleared only by rst

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, sc_start=0, sc_data_in=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, err_sticky=0, last_id=N_REQ-1 (requester 0 has first priority), timer=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, req!=0:
  - Choose the first set bit searching last_id+1, last_id+2, ... mod N_REQ.
  - Latch gnt_id and req_data[gnt_id] into op_reg.
  - Go to ISSUE.
- IDLE, req==0: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - sc_start=1; sc_data_in=op_reg.
  - sc_data_in holds op_reg from ISSUE through WAIT.
  - Timer is cleared; go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - If sc_done=1: latch sc_data_out into rsp_data, set rsp_err=0, go to RESP.
  - Else if timer==TIMEOUT-1: rsp_data=0, rsp_err=1, err_sticky=1, go to RESP.
  - If sc_done and the timeout coincide in the same cycle, done wins and no error is raised.
- RESP (exactly 1 cycle):
  - rsp_valid[gnt_id]=1.
  - last_id=gnt_id.
  - Go to IDLE.
- Registered outputs: rsp_valid, rsp_data, rsp_err are registered, so rsp_valid is high during the RESP cycle.
- Latency: from req sampled in IDLE to rsp_valid = 3 + L cycles, where L is the number of WAIT cycles up to and including the sc_done cycle.
- Back-to-back grants: the minimum turnaround between grants is 1 IDLE cycle.
- Requester contract:
  - A requester deasserts req on the edge that ends its rsp_valid cycle.
  - IDLE then sees the updated req vector.
- Request withdrawn mid-service: if req[gnt_id] drops after the grant, the transaction still completes and rsp_valid is still issued.
- Operand capture: req_data is sampled only at grant. Changes to req_data after the grant are ignored.
- Stray done: sc_done in IDLE, ISSUE or RESP is ignored.
- After a timeout:
  - step_controller has no abort and may still be busy.
  - The system must reset it before further use.
  - err_sticky flags this condition.
- Fairness: a continuously requesting port waits at most N_REQ-1 transactions.
- Reset mid-operation: all state returns to reset values on the next edge. Any in-flight response is lost and no rsp_valid is issued.

Decomposition:
- Package step_pkg holds:
  - the arbiter state enum (IDLE/ISSUE/WAIT/RESP, 2 bits);
  - the existing step_controller state constants;
  - DATA_W default 8.
- TIMER_W=$clog2(TIMEOUT) is computed locally.
- Sub-module rr_pick (combinational):
  - inputs: req, last_id;
  - outputs: gnt_id, any;
  - implemented as a rotate, then priority encode, then rotate back.

Test Plan:
- Single request: req=4'b0001, req_data[0]=8'h12, model returns 8'h5A after L=7 -> sc_start pulses once with sc_data_in=8'h12; rsp_valid=4'b0001 and rsp_data=8'h5A at cycle 10 after request; busy falls the following cycle.
- All four requesters held with operands 8'h01..8'h04 -> grants in order 0,1,2,3,0; each rsp_data matches the model result for its own operand; every transaction has exactly one sc_start.
- Model never asserts sc_done, TIMEOUT=64 -> rsp_valid[gnt] with rsp_err=1 and rsp_data=0 at 64 WAIT cycles; err_sticky=1 and stays 1 until rst.
- sc_done in the same cycle as timer==TIMEOUT-1 -> rsp_err=0, result delivered, err_sticky stays 0; a stray sc_done pulse in IDLE -> no state change.
- req[2] dropped and req_data[2] changed one cycle after grant -> original operand used, rsp_valid=4'b0100 still issued.
- rst asserted during WAIT -> the next cycle shows all outputs at reset values; no rsp_valid; the next request from port 0 is granted first.
